print_uart_tx: RTL and testbench

Serial console stage downstream of the PicoRV32 wrapper's 49-bit `print_out` bus. Each cycle that `print_out[48]` is high, the byte in `print_out[7:0]` is queued into an internal FIFO. Queued bytes are transmitted on a single TX line as 8N1 UART frames, so firmware writes to 0x1000_0000 reach a host terminal without stalling the core.

---
 rtl/print_uart_tx.sv | 168 ++++++++++++++++
 tb/tb_print_uart_tx.sv | 311 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/print_uart_tx.sv
// print_uart_tx: queues bytes strobed on the core's print bus and drains
// them as 8N1 UART frames on a registered TX line.
module print_uart_tx #(
    parameter int CLKS_PER_BIT = 868,
    parameter int FIFO_AW      = 4
) (
    input  logic               clk,
    input  logic               reset,
    input  logic [48:0]        print_in,
    output logic               tx,
    output logic               busy,
    output logic [FIFO_AW:0]   fifo_count,
    output logic               overflow
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam logic [FIFO_AW:0]   LP_FULL = (FIFO_AW + 1)'(DEPTH);
    localparam logic [FIFO_AW:0]   LP_CONE = (FIFO_AW + 1)'(1);
    localparam logic [FIFO_AW-1:0] LP_PONE = FIFO_AW'(1);
    localparam logic [15:0]        LP_LAST = 16'(CLKS_PER_BIT - 1);

    typedef enum logic [1:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_STOP
    } state_t;

    logic [7:0]         r_mem [DEPTH];
    logic [FIFO_AW-1:0] r_wptr;
    logic [FIFO_AW-1:0] r_rptr;
    logic [FIFO_AW:0]   r_count;
    logic               r_overflow;
    logic               r_busy;

    state_t             r_state;
    logic [15:0]        r_baud;
    logic [2:0]         r_bit;
    logic [7:0]         r_shift;
    logic               r_tx;

    logic               w_strobe;
    logic               w_full;
    logic               w_push;
    logic               w_pop;
    logic               w_tick;
    logic               w_next_idle;
    logic [FIFO_AW:0]   w_count_nxt;
    logic               w_unused;

    assign w_strobe = print_in[48];
    assign w_unused = ^print_in[47:8];

    // Full is judged on the registered count, so a same-cycle pop never
    // makes room for the push.
    assign w_full = (r_count == LP_FULL);
    assign w_push = w_strobe & ~w_full;
    assign w_pop  = (r_state == S_IDLE) & (r_count != '0);
    assign w_tick = (r_baud == LP_LAST);

    always_comb begin
        w_count_nxt = r_count;
        if (w_push & ~w_pop) begin
            w_count_nxt = r_count + LP_CONE;
        end else if (w_pop & ~w_push) begin
            w_count_nxt = r_count - LP_CONE;
        end
    end

    assign w_next_idle = ((r_state == S_IDLE) & ~w_pop) |
                         ((r_state == S_STOP) & w_tick);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wptr] <= print_in[7:0];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wptr     <= '0;
            r_rptr     <= '0;
            r_count    <= '0;
            r_overflow <= 1'b0;
            r_busy     <= 1'b0;
        end else begin
            if (w_push) begin
                r_wptr <= r_wptr + LP_PONE;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + LP_PONE;
            end
            if (w_strobe & w_full) begin
                r_overflow <= 1'b1;
            end
            r_count <= w_count_nxt;
            // Built from next-state values so busy tracks the cycle it lands in.
            r_busy  <= ~w_next_idle | (w_count_nxt != '0);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            unique case (r_state)
                S_IDLE: begin
                    if (w_pop) begin
                        r_shift <= r_mem[r_rptr];
                        r_baud  <= '0;
                        r_bit   <= '0;
                        r_state <= S_START;
                        r_tx    <= 1'b0;
                    end else begin
                        r_tx    <= 1'b1;
                    end
                end
                S_START: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_state <= S_DATA;
                        r_tx    <= r_shift[0];
                    end else begin
                        r_baud  <= r_baud + 16'd1;
                    end
                end
                S_DATA: begin
                    if (w_tick) begin
                        r_baud <= '0;
                        if (r_bit == 3'd7) begin
                            r_state <= S_STOP;
                            r_tx    <= 1'b1;
                        end else begin
                            r_shift <= r_shift >> 1;
                            r_bit   <= r_bit + 3'd1;
                            r_tx    <= r_shift[1];
                        end
                    end else begin
                        r_baud <= r_baud + 16'd1;
                    end
                end
                S_STOP: begin
                    if (w_tick) begin
                        r_baud  <= '0;
                        r_state <= S_IDLE;
                        r_tx    <= 1'b1;
                    end else begin
                        r_baud  <= r_baud + 16'd1;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                    r_tx    <= 1'b1;
                end
            endcase
        end
    end

    assign tx         = r_tx;
    assign busy       = r_busy;
    assign fifo_count = r_count;
    assign overflow   = r_overflow;

endmodule

// File: tb/tb_print_uart_tx.sv
// Bench for print_uart_tx: directed vectors plus a background UART
// decoder that records every frame seen on tx.
module tb_print_uart_tx;

    logic        clk = 1'b0;
    logic        reset;
    logic [48:0] print_in;
    logic        tx;
    logic        busy;
    logic [4:0]  fifo_count;
    logic        overflow;

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    logic [7:0] q_byte[$];
    int         q_start[$];
    logic       q_ok[$];

    typedef struct {
        logic [39:0] hi;
        logic [7:0]  data;
        logic [7:0]  exp;
    } vec_t;

    vec_t vecs[5];

    print_uart_tx #(
        .CLKS_PER_BIT(4),
        .FIFO_AW(4)
    ) dut (
        .clk(clk),
        .reset(reset),
        .print_in(print_in),
        .tx(tx),
        .busy(busy),
        .fifo_count(fifo_count),
        .overflow(overflow)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

    // Background decoder: samples mid-bit for CLKS_PER_BIT=4.
    initial begin
        int s;
        logic [7:0] b;
        logic ok;
        forever begin
            @(posedge clk); #2;
            if (reset === 1'b0 && tx === 1'b0) begin
                s  = cyc;
                ok = 1'b1;
                repeat (2) @(posedge clk);
                #2;
                if (tx !== 1'b0) ok = 1'b0;
                for (int i = 0; i < 8; i++) begin
                    repeat (4) @(posedge clk);
                    #2;
                    b[i] = tx;
                end
                repeat (4) @(posedge clk);
                #2;
                if (tx !== 1'b1) ok = 1'b0;
                q_byte.push_back(b);
                q_start.push_back(s);
                q_ok.push_back(ok);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flush();
        q_byte.delete();
        q_start.delete();
        q_ok.delete();
    endtask

    task automatic strobe(input logic [7:0] b);
        print_in = {1'b1, 40'h0, b};
    endtask

    task automatic wait_frames(input int n, input int limit);
        int k = 0;
        while (q_byte.size() < n && k < limit) begin
            tick();
            k++;
        end
        chk("frames_arrived", q_byte.size(), n);
    endtask

    task automatic wait_idle(input int limit);
        int k = 0;
        while (busy !== 1'b0 && k < limit) begin
            tick();
            k++;
        end
        chk("idle_reached", busy, 1'b0);
    endtask

    initial begin
        int k;
        int viol;
        logic exp_tx;
        logic exp_busy;
        logic [7:0] bits41;

        vecs[0] = '{hi: 40'h0,            data: 8'h00, exp: 8'h00};
        vecs[1] = '{hi: 40'hFF_FFFF_FFFF, data: 8'h5A, exp: 8'h5A};
        vecs[2] = '{hi: 40'hDE_ADBE_EF01, data: 8'hFF, exp: 8'hFF};
        vecs[3] = '{hi: 40'h12_3456_789A, data: 8'h80, exp: 8'h80};
        vecs[4] = '{hi: 40'hA5_5A5A_A5A5, data: 8'h01, exp: 8'h01};

        reset    = 1'b1;
        print_in = '0;
        repeat (3) tick();
        reset = 1'b0;
        tick();

        chk("rst_tx", tx, 1'b1);
        chk("rst_busy", busy, 1'b0);
        chk("rst_count", fifo_count, 5'd0);
        chk("rst_ovf", overflow, 1'b0);

        // Single byte 0x41: per-cycle tx and busy against hand-built frame.
        bits41 = 8'b0100_0001;
        flush();
        k = cyc;
        strobe(8'h41);
        for (int c = 0; c <= 42; c++) begin
            if (c < 2)       exp_tx = 1'b1;
            else if (c < 6)  exp_tx = 1'b0;
            else if (c < 38) exp_tx = bits41[(c - 6) / 4];
            else             exp_tx = 1'b1;
            exp_busy = (c >= 1) && (c <= 41);
            chk($sformatf("one_tx_c%0d", c), tx, exp_tx);
            chk($sformatf("one_busy_c%0d", c), busy, exp_busy);
            if (c == 1) chk("one_count_c1", fifo_count, 5'd1);
            if (c == 2) chk("one_count_c2", fifo_count, 5'd0);
            tick();
            print_in = '0;
        end
        chk("one_frames", q_byte.size(), 1);
        if (q_byte.size() > 0) begin
            chk("one_byte", q_byte[0], 8'h41);
            chk("one_start", q_start[0] - k, 2);
        end

        // Table: high bits of print_in must never leak into the frame.
        for (int v = 0; v < 5; v++) begin
            flush();
            k = cyc;
            print_in = {1'b1, vecs[v].hi, vecs[v].data};
            tick();
            print_in = '0;
            wait_frames(1, 80);
            if (q_byte.size() > 0) begin
                chk($sformatf("vec%0d_byte", v), q_byte[0], vecs[v].exp);
                chk($sformatf("vec%0d_start", v), q_start[0] - k, 2);
                chk($sformatf("vec%0d_stop", v), q_ok[0], 1'b1);
            end
            wait_idle(20);
            tick();
        end

        viol = 0;
        for (int c = 0; c < 100; c++) begin
            print_in = {1'b0, 16'($urandom), 32'($urandom)};
            tick();
            if (tx !== 1'b1 || fifo_count !== 5'd0) viol++;
        end
        print_in = '0;
        chk("ignored_viol", viol, 0);
        tick();

        // Back-to-back three bytes.
        flush();
        k = cyc;
        strobe(8'h55);
        tick();
        chk("b2b_count_c1", fifo_count, 5'd1);
        strobe(8'hAA);
        tick();
        chk("b2b_tx_c2", tx, 1'b0);
        chk("b2b_count_c2", fifo_count, 5'd1);
        strobe(8'h0F);
        tick();
        print_in = '0;
        chk("b2b_count_c3", fifo_count, 5'd2);
        wait_frames(3, 200);
        if (q_byte.size() >= 3) begin
            chk("b2b_byte0", q_byte[0], 8'h55);
            chk("b2b_byte1", q_byte[1], 8'hAA);
            chk("b2b_byte2", q_byte[2], 8'h0F);
            chk("b2b_start0", q_start[0] - k, 2);
            chk("b2b_start1", q_start[1] - k, 43);
            chk("b2b_start2", q_start[2] - k, 84);
        end
        wait_idle(20);
        tick();

        // Overflow: 20 consecutive strobes into a 16-deep FIFO.
        flush();
        for (int i = 0; i < 20; i++) begin
            strobe(8'(i));
            if (i == 16) chk("ovf_count_c16", fifo_count, 5'd15);
            if (i == 17) begin
                chk("ovf_count_c17", fifo_count, 5'd16);
                chk("ovf_flag_c17", overflow, 1'b0);
            end
            if (i == 18) begin
                chk("ovf_count_c18", fifo_count, 5'd16);
                chk("ovf_flag_c18", overflow, 1'b1);
            end
            tick();
        end
        print_in = '0;
        wait_frames(17, 17 * 41 + 60);
        wait_idle(60);
        repeat (60) tick();
        chk("ovf_frames", q_byte.size(), 17);
        for (int i = 0; i < 17 && i < q_byte.size(); i++) begin
            chk($sformatf("ovf_byte%0d", i), q_byte[i], 8'(i));
        end
        chk("ovf_sticky", overflow, 1'b1);

        // Reset during data bit 3 of 0x11 (bit3=0, so tx is low there).
        flush();
        k = cyc;
        strobe(8'h11);
        tick();
        strobe(8'h22);
        tick();
        strobe(8'h33);
        tick();
        strobe(8'h44);
        tick();
        strobe(8'h55);
        tick();
        print_in = '0;
        repeat (14) tick();
        chk("rmf_cycle", cyc - k, 19);
        chk("rmf_tx_bit3", tx, 1'b0);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        chk("rmf_tx", tx, 1'b1);
        chk("rmf_count", fifo_count, 5'd0);
        chk("rmf_busy", busy, 1'b0);
        chk("rmf_ovf", overflow, 1'b0);
        repeat (60) tick();
        flush();
        k = cyc;
        strobe(8'h7E);
        tick();
        print_in = '0;
        wait_frames(1, 80);
        if (q_byte.size() > 0) begin
            chk("rmf_byte", q_byte[0], 8'h7E);
            chk("rmf_start", q_start[0] - k, 2);
            chk("rmf_stop", q_ok[0], 1'b1);
        end
        wait_idle(20);
        repeat (60) tick();
        chk("rmf_no_stale", q_byte.size(), 1);

        // Wrap-around: 40 bytes at one per 42 cycles.
        flush();
        for (int i = 0; i < 40; i++) begin
            strobe(8'(i * 7 + 3));
            tick();
            print_in = '0;
            repeat (41) tick();
        end
        wait_frames(40, 200);
        wait_idle(60);
        chk("wrap_frames", q_byte.size(), 40);
        viol = 0;
        for (int i = 0; i < 40 && i < q_byte.size(); i++) begin
            if (q_byte[i] !== 8'(i * 7 + 3) || q_ok[i] !== 1'b1) viol++;
        end
        chk("wrap_order", viol, 0);
        chk("wrap_ovf", overflow, 1'b0);
        chk("wrap_count", fifo_count, 5'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
